// File: rtl/serial_subtractor.sv
`timescale 1ns/1ps
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one full-subtractor stage per clock.
// start accepted in IDLE or DONE; done pulses WIDTH+1 clocks later; start is ignored while busy.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] rd_q, rd_d;
    logic           br_q, br_d;
    logic           bo_q, bo_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic x, y, d_bit, br_next;
    logic load;

    assign x       = ra_q[0];
    assign y       = rb_q[0];
    assign d_bit   = x ^ y ^ br_q;
    assign br_next = (~x & y) | (~(x ^ y) & br_q);

    // DONE behaves like IDLE for start acceptance, giving back-to-back operation.
    assign load = start && ((state_q == IDLE) || (state_q == DONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            rd_q    <= '0;
            br_q    <= 1'b0;
            bo_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rd_q    <= rd_d;
            br_q    <= br_d;
            bo_q    <= bo_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (cnt_q == CNT_LAST) state_d = DONE;
            DONE:    state_d = start ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ra_d  = ra_q;
        rb_d  = rb_q;
        rd_d  = rd_q;
        br_d  = br_q;
        bo_d  = bo_q;
        cnt_d = cnt_q;
        if (load) begin
            ra_d  = a;
            rb_d  = b;
            br_d  = 1'b0;
            cnt_d = '0;
        end else if (state_q == SHIFT) begin
            rd_d  = {d_bit, rd_q[WIDTH-1:1]};
            ra_d  = {1'b0, ra_q[WIDTH-1:1]};
            rb_d  = {1'b0, rb_q[WIDTH-1:1]};
            br_d  = br_next;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) bo_d = br_next;
        end
    end

    always_comb begin
        busy       = (state_q == SHIFT);
        done       = (state_q == DONE);
        diff       = rd_q;
        borrow_out = bo_q;
    end

endmodule
